// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the front-end controller and pc_sequencer.
// master drives the control inputs; slave is the sequencer itself.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             halt;
    logic             redir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] target;
    logic             call;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus;
    logic             halted;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    modport master (
        output stall, halt, redir, mode, target, call,
        input  pc_out, pc_plus, halted, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, halt, redir, mode, target, call,
        output pc_out, pc_plus, halted, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with stall/halt, PC-relative/absolute redirects and an
// optional return-address stack enabled by macro PC_RAS_EN; state moves on negedge clk.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    typedef enum logic {RUN, HALTED} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two >= 2");
    end

    assign pc_plus = pc_q + WIDTH'(STEP);

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // sp points at the next free slot; when full it also points at the oldest entry
    logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_mem_q, ras_mem_d;
    logic [PTR_W-1:0]                sp_q, sp_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            do_pop, do_push;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_RAS_EN
        ras_mem_d = ras_mem_q;
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        do_pop    = 1'b0;
        do_push   = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_plus;
                        if (bus.redir) begin
                            case (bus.mode)
                                2'b01:   pc_d = pc_q + bus.target;
                                2'b10:   pc_d = bus.target;
`ifdef PC_RAS_EN
                                2'b11:   do_pop = 1'b1;
`else
                                2'b11:   pc_d = bus.target;
`endif
                                default: pc_d = pc_plus;
                            endcase
`ifdef PC_RAS_EN
                            do_push = bus.call;
`endif
                        end
                    end
                end
            end
            default: state_d = HALTED;
        endcase
`ifdef PC_RAS_EN
        // pop resolves before push so a return+call swaps the top in place
        if (do_pop) begin
            if (cnt_q == '0) begin
                pc_d  = pc_plus;
                err_d = 1'b1;
            end else begin
                pc_d  = ras_mem_q[sp_q - PTR_W'(1)];
                sp_d  = sp_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (do_push) begin
            ras_mem_d[sp_d] = pc_plus;
            sp_d            = sp_d + PTR_W'(1);
            if (cnt_d == CNT_W'(RAS_DEPTH)) err_d = 1'b1;
            else                            cnt_d = cnt_d + CNT_W'(1);
        end
`endif
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(negedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // stack contents need no reset: count gates every read
    always_ff @(negedge clk) begin
        ras_mem_q <= ras_mem_d;
    end

    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign bus.ras_err   = err_q;
`else
    logic unused_call;
    assign unused_call   = bus.call;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

    assign bus.pc_out  = pc_q;
    assign bus.pc_plus = pc_plus;
    assign bus.halted  = (state_q == HALTED);
endmodule
